dfd_apb_req_arbiter: RTL and testbench

// - Shares the single APB slave port of the DFD MMR block (dfd_top / dfd_top_cla_dst_mmr) between NUM_REQ requesters.
// - Typical requesters are the JTAG debug path and the core MMIO path.
// - Grants one requester at a time using round-robin arbitration, then sequences the APB setup and access phases.
// - Returns read data and error status to the requester that was granted.
// - Bounds a hung slave with an access-phase timeout.

---
 rtl/dfd_pkg.sv | 22 ++
 rtl/dfd_rr_arbiter.sv | 48 ++++
 rtl/dfd_apb_req_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dfd_apb_req_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfd_pkg.sv
// Shared types and widths for the DFD APB request arbiter and related bus-sharing logic.
package dfd_pkg;

  localparam int unsigned DFD_APB_ADDR_WIDTH  = 23;
  localparam int unsigned DFD_APB_DATA_WIDTH  = 32;
  localparam int unsigned DFD_APB_PSTRB_WIDTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } dfd_apb_arb_state_e;

  // Latched APB request; sized by the package widths.
  typedef struct packed {
    logic [DFD_APB_ADDR_WIDTH-1:0]  addr;
    logic                           write;
    logic [DFD_APB_DATA_WIDTH-1:0]  wdata;
    logic [DFD_APB_PSTRB_WIDTH-1:0] strb;
  } dfd_apb_req_t;

endpackage

// File: rtl/dfd_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot winner plus the priority pointer register.
// The winner is the first requesting index strictly after the pointer, modulo NUM_REQ.
module dfd_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_grant,
  output logic [NUM_REQ-1:0] o_gnt_onehot,
  output logic [IdxW-1:0]    o_gnt_idx,
  output logic               o_any
);

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] w_idx;
  logic            w_found;
  int unsigned     w_cand;

  // Scan from pointer+1 around to the pointer itself; first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = (32'(r_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[IdxW'(w_cand)]) begin
        w_found = 1'b1;
        w_idx   = IdxW'(w_cand);
      end
    end
  end

  assign o_any        = w_found;
  assign o_gnt_idx    = w_idx;
  assign o_gnt_onehot = w_found ? (NUM_REQ'(1) << w_idx) : '0;

  // Pointer moves to the winner only when the grant is actually taken.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_ptr <= IdxW'(NUM_REQ - 1);
    end else if (i_grant && w_found) begin
      r_ptr <= w_idx;
    end
  end

endmodule

// File: rtl/dfd_apb_req_arbiter.sv
// Shares one APB master port between NUM_REQ requesters: round-robin grant, APB setup/access
// sequencing, registered per-requester response and an access-phase timeout.
module dfd_apb_req_arbiter
  import dfd_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = DFD_APB_ADDR_WIDTH,
  parameter int unsigned DATA_W         = DFD_APB_DATA_WIDTH,
  parameter int unsigned STRB_W         = DFD_APB_PSTRB_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0]             i_req_write,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] i_req_wdata,
  input  logic [NUM_REQ-1:0][STRB_W-1:0] i_req_strb,
  output logic [NUM_REQ-1:0]             o_rsp_valid,
  output logic [DATA_W-1:0]              o_rsp_rdata,
  output logic                           o_rsp_err,
  output logic                           o_rsp_timeout,
  output logic                           o_timeout_sticky,
  output logic [ADDR_W-1:0]              o_paddr,
  output logic                           o_psel,
  output logic                           o_penable,
  output logic [STRB_W-1:0]              o_pstrb,
  output logic                           o_pwrite,
  output logic [DATA_W-1:0]              o_pwdata,
  input  logic                           i_pready,
  input  logic [DATA_W-1:0]              i_prdata,
  input  logic                           i_pslverr
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax =
      (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);

  dfd_apb_arb_state_e r_state, w_state_d;
  dfd_apb_req_t       r_req, w_req_d;
  logic [IdxW-1:0]    r_idx, w_idx_d;
  logic [CntW-1:0]    r_cnt, w_cnt_d;
  logic [NUM_REQ-1:0] r_rsp_valid, w_rsp_valid_d;
  logic [DATA_W-1:0]  r_rsp_rdata, w_rsp_rdata_d;
  logic               r_rsp_err, w_rsp_err_d;
  logic               r_rsp_timeout, w_rsp_timeout_d;
  logic               r_sticky, w_sticky_d;

  logic               w_grant;
  logic               w_any;
  logic               w_expire;
  logic [IdxW-1:0]    w_win_idx;
  logic [NUM_REQ-1:0] w_win_onehot;

  dfd_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_req        (i_req_valid),
    .i_grant      (w_grant),
    .o_gnt_onehot (w_win_onehot),
    .o_gnt_idx    (w_win_idx),
    .o_any        (w_any)
  );

  assign w_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == CntMax);

  // Next-state, request latch, timeout counter and response generation.
  always_comb begin
    w_state_d       = r_state;
    w_req_d         = r_req;
    w_idx_d         = r_idx;
    w_cnt_d         = r_cnt;
    w_rsp_valid_d   = '0;
    w_rsp_rdata_d   = '0;
    w_rsp_err_d     = 1'b0;
    w_rsp_timeout_d = 1'b0;
    w_sticky_d      = r_sticky;
    w_grant         = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Gated by reset so req_ready stays low while reset is asserted.
        if (w_any && i_reset_n) begin
          w_grant       = 1'b1;
          w_state_d     = StSetup;
          w_cnt_d       = '0;
          w_idx_d       = w_win_idx;
          w_req_d.addr  = DFD_APB_ADDR_WIDTH'(i_req_addr[w_win_idx]);
          w_req_d.write = i_req_write[w_win_idx];
          w_req_d.wdata = i_req_write[w_win_idx] ?
                          DFD_APB_DATA_WIDTH'(i_req_wdata[w_win_idx]) : '0;
          w_req_d.strb  = i_req_write[w_win_idx] ?
                          DFD_APB_PSTRB_WIDTH'(i_req_strb[w_win_idx]) : '0;
        end
      end
      StSetup: begin
        w_state_d = StAccess;
      end
      StAccess: begin
        // pready wins over a simultaneous timeout expiry.
        if (i_pready) begin
          w_state_d     = StIdle;
          w_rsp_valid_d = NUM_REQ'(1) << r_idx;
          w_rsp_rdata_d = r_req.write ? '0 : i_prdata;
          w_rsp_err_d   = i_pslverr;
        end else if (w_expire) begin
          w_state_d       = StIdle;
          w_rsp_valid_d   = NUM_REQ'(1) << r_idx;
          w_rsp_err_d     = 1'b1;
          w_rsp_timeout_d = 1'b1;
          w_sticky_d      = 1'b1;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight transfer silently.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state       <= StIdle;
      r_req         <= '0;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_rsp_valid   <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_sticky      <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_req         <= w_req_d;
      r_idx         <= w_idx_d;
      r_cnt         <= w_cnt_d;
      r_rsp_valid   <= w_rsp_valid_d;
      r_rsp_rdata   <= w_rsp_rdata_d;
      r_rsp_err     <= w_rsp_err_d;
      r_rsp_timeout <= w_rsp_timeout_d;
      r_sticky      <= w_sticky_d;
    end
  end

  assign o_req_ready      = w_grant ? w_win_onehot : '0;
  assign o_psel           = (r_state != StIdle);
  assign o_penable        = (r_state == StAccess);
  assign o_paddr          = ADDR_W'(r_req.addr);
  assign o_pwrite         = r_req.write;
  assign o_pwdata         = DATA_W'(r_req.wdata);
  assign o_pstrb          = STRB_W'(r_req.strb);
  assign o_rsp_valid      = r_rsp_valid;
  assign o_rsp_rdata      = r_rsp_rdata;
  assign o_rsp_err        = r_rsp_err;
  assign o_rsp_timeout    = r_rsp_timeout;
  assign o_timeout_sticky = r_sticky;

endmodule

// File: tb/tb_dfd_apb_req_arbiter.sv
// Directed self-checking bench for dfd_apb_req_arbiter (2 requesters, 16-cycle timeout).
module tb_dfd_apb_req_arbiter;

  logic            clk;
  logic            reset_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][22:0] req_addr;
  logic [1:0]      req_write;
  logic [1:0][31:0] req_wdata;
  logic [1:0][3:0] req_strb;
  logic [1:0]      rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic            rsp_timeout;
  logic            timeout_sticky;
  logic [22:0]     paddr;
  logic            psel;
  logic            penable;
  logic [3:0]      pstrb;
  logic            pwrite;
  logic [31:0]     pwdata;
  logic            pready;
  logic [31:0]     prdata;
  logic            pslverr;

  int n_pass  = 0;
  int n_total = 0;

  dfd_apb_req_arbiter #(
    .NUM_REQ        (2),
    .ADDR_W         (23),
    .DATA_W         (32),
    .STRB_W         (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (reset_n),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_addr       (req_addr),
    .i_req_write      (req_write),
    .i_req_wdata      (req_wdata),
    .i_req_strb       (req_strb),
    .o_rsp_valid      (rsp_valid),
    .o_rsp_rdata      (rsp_rdata),
    .o_rsp_err        (rsp_err),
    .o_rsp_timeout    (rsp_timeout),
    .o_timeout_sticky (timeout_sticky),
    .o_paddr          (paddr),
    .o_psel           (psel),
    .o_penable        (penable),
    .o_pstrb          (pstrb),
    .o_pwrite         (pwrite),
    .o_pwdata         (pwdata),
    .i_pready         (pready),
    .i_prdata         (prdata),
    .i_pslverr        (pslverr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 2'b11;
    req_addr[0] = 23'h000100;
    req_addr[1] = 23'h000200;
    req_write = 2'b00;
    req_wdata = '0;
    req_strb  = '0;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;
    repeat (3) step();
    settle();
    n_total++;
    if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", req_ready);
    else n_pass++;
    n_total++;
    if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== '0)
      $display("FAIL reset_apb: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h pstrb=%h want all 0",
               psel, penable, pwrite, paddr, pwdata, pstrb);
    else n_pass++;
    n_total++;
    if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, timeout_sticky} !== '0)
      $display("FAIL reset_rsp: got v=%b d=%h e=%b t=%b s=%b want all 0",
               rsp_valid, rsp_rdata, rsp_err, rsp_timeout, timeout_sticky);
    else n_pass++;
  endtask

  // Both requesters held valid from reset release; pready held high throughout.
  task automatic test_rr_from_reset();
    logic [1:0]  exp_ready [4];
    logic [22:0] exp_addr  [4];
    exp_ready[0] = 2'b01; exp_ready[1] = 2'b10; exp_ready[2] = 2'b01; exp_ready[3] = 2'b10;
    exp_addr[0]  = 23'h000100; exp_addr[1] = 23'h000200;
    exp_addr[2]  = 23'h000100; exp_addr[3] = 23'h000200;
    pready = 1'b1;
    prdata = 32'h000000A5;
    step();
    reset_n = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c != 0) step();
      if (c == 10) req_valid = 2'b00;
      settle();
      if (c % 3 == 0) begin
        n_total++;
        if (c < 12) begin
          if (req_ready !== exp_ready[c/3] || psel !== 1'b0)
            $display("FAIL rr_grant%0d: got ready=%b psel=%b want ready=%b psel=0",
                     c/3, req_ready, psel, exp_ready[c/3]);
          else n_pass++;
        end else begin
          if (req_ready !== 2'b00 || psel !== 1'b0)
            $display("FAIL rr_idle_end: got ready=%b psel=%b want 00/0", req_ready, psel);
          else n_pass++;
        end
        if (c > 0) begin
          n_total++;
          if (rsp_valid !== exp_ready[c/3-1] || rsp_rdata !== 32'h000000A5)
            $display("FAIL rr_rsp%0d: got v=%b d=%h want v=%b d=000000a5",
                     c/3-1, rsp_valid, rsp_rdata, exp_ready[c/3-1]);
          else n_pass++;
        end
      end else if (c % 3 == 1) begin
        n_total++;
        if (psel !== 1'b1 || penable !== 1'b0 || paddr !== exp_addr[c/3])
          $display("FAIL rr_setup%0d: got psel=%b pen=%b paddr=%h want 1/0/%h",
                   c/3, psel, penable, paddr, exp_addr[c/3]);
        else n_pass++;
      end else begin
        n_total++;
        if (psel !== 1'b1 || penable !== 1'b1)
          $display("FAIL rr_access%0d: got psel=%b pen=%b want 1/1", c/3, psel, penable);
        else n_pass++;
      end
    end
    pready = 1'b0;
  endtask

  task automatic test_single_read();
    req_addr[0]  = 23'h000248;
    req_write[0] = 1'b0;
    pready = 1'b0;
    step();
    req_valid = 2'b01;
    settle();
    n_total++;
    if (req_ready !== 2'b01 || psel !== 1'b0)
      $display("FAIL rd_accept: got ready=%b psel=%b want 01/0", req_ready, psel);
    else n_pass++;
    step();
    req_valid = 2'b00;
    settle();
    n_total++;
    if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 23'h000248 || pwrite !== 1'b0 ||
        pwdata !== 32'h0 || pstrb !== 4'h0)
      $display("FAIL rd_setup: got psel=%b pen=%b paddr=%h pw=%b pwdata=%h pstrb=%h",
               psel, penable, paddr, pwrite, pwdata, pstrb);
    else n_pass++;
    step();
    pready = 1'b1;
    prdata = 32'hDEADBEEF;
    settle();
    n_total++;
    if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 2'b00)
      $display("FAIL rd_access: got psel=%b pen=%b rspv=%b want 1/1/00", psel, penable, rsp_valid);
    else n_pass++;
    step();
    pready = 1'b0;
    settle();
    n_total++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 ||
        rsp_timeout !== 1'b0 || psel !== 1'b0)
      $display("FAIL rd_rsp: got v=%b d=%h e=%b t=%b psel=%b want 01/deadbeef/0/0/0",
               rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel);
    else n_pass++;
    step();
    settle();
    n_total++;
    if (rsp_valid !== 2'b00)
      $display("FAIL rd_rsp_pulse: got %b want 00", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_write_wait();
    int n_pen = 0;
    req_addr[0]  = 23'h166040;
    req_write[0] = 1'b1;
    req_wdata[0] = 32'hBEEFDEAD;
    req_strb[0]  = 4'hF;
    prdata = 32'h12345678;
    pready = 1'b0;
    step();
    req_valid = 2'b01;
    settle();
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL wr_accept: got %b want 01", req_ready);
    else n_pass++;
    step();
    req_valid = 2'b00;
    settle();
    n_total++;
    if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 23'h166040 || pwdata !== 32'hBEEFDEAD ||
        pstrb !== 4'hF || pwrite !== 1'b1)
      $display("FAIL wr_setup: got psel=%b pen=%b paddr=%h pwdata=%h pstrb=%h pw=%b",
               psel, penable, paddr, pwdata, pstrb, pwrite);
    else n_pass++;
    for (int w = 0; w < 4; w++) begin
      step();
      pready = (w == 3);
      settle();
      if (penable === 1'b1) n_pen++;
      n_total++;
      if (psel !== 1'b1 || paddr !== 23'h166040 || pwdata !== 32'hBEEFDEAD || pstrb !== 4'hF ||
          pwrite !== 1'b1 || rsp_valid !== 2'b00)
        $display("FAIL wr_stable%0d: got psel=%b paddr=%h pwdata=%h pstrb=%h pw=%b rspv=%b",
                 w, psel, paddr, pwdata, pstrb, pwrite, rsp_valid);
      else n_pass++;
    end
    step();
    pready = 1'b0;
    settle();
    n_total++;
    if (n_pen != 4) $display("FAIL wr_penable_cycles: got %0d want 4", n_pen);
    else n_pass++;
    n_total++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || psel !== 1'b0)
      $display("FAIL wr_rsp: got v=%b d=%h e=%b psel=%b want 01/00000000/0/0",
               rsp_valid, rsp_rdata, rsp_err, psel);
    else n_pass++;
    req_write[0] = 1'b0;
  endtask

  task automatic test_slverr();
    req_addr[1]  = 23'h000300;
    req_write[1] = 1'b0;
    step();
    req_valid = 2'b10;
    settle();
    n_total++;
    if (req_ready !== 2'b10) $display("FAIL err_accept: got %b want 10", req_ready);
    else n_pass++;
    step();
    req_valid = 2'b00;
    step();
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'hCAFE0001;
    step();
    pready  = 1'b0;
    pslverr = 1'b0;
    settle();
    n_total++;
    if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 ||
        rsp_rdata !== 32'hCAFE0001)
      $display("FAIL err_rsp: got v=%b e=%b t=%b d=%h want 10/1/0/cafe0001",
               rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n_pen = 0;
    req_addr[0]  = 23'h000010;
    req_write[0] = 1'b0;
    pready = 1'b0;
    prdata = 32'hFFFFFFFF;
    step();
    req_valid = 2'b01;
    settle();
    step();
    req_valid = 2'b00;
    settle();
    for (int a = 0; a < 16; a++) begin
      step();
      settle();
      if (penable === 1'b1) n_pen++;
    end
    n_total++;
    if (penable !== 1'b1 || rsp_valid !== 2'b00)
      $display("FAIL to_last_access: got pen=%b rspv=%b want 1/00", penable, rsp_valid);
    else n_pass++;
    step();
    pready = 1'b1;
    settle();
    n_total++;
    if (n_pen != 16) $display("FAIL to_access_cycles: got %0d want 16", n_pen);
    else n_pass++;
    n_total++;
    if (psel !== 1'b0 || rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1 ||
        rsp_rdata !== 32'h0 || timeout_sticky !== 1'b1)
      $display("FAIL to_rsp: got psel=%b v=%b e=%b t=%b d=%h s=%b want 0/01/1/1/0/1",
               psel, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, timeout_sticky);
    else n_pass++;
    step();
    settle();
    n_total++;
    if (rsp_valid !== 2'b00 || psel !== 1'b0 || timeout_sticky !== 1'b1)
      $display("FAIL to_late_pready: got v=%b psel=%b s=%b want 00/0/1",
               rsp_valid, psel, timeout_sticky);
    else n_pass++;
    pready = 1'b0;
  endtask

  task automatic test_reset_in_access();
    req_addr[0] = 23'h000040;
    req_addr[1] = 23'h000080;
    req_write   = 2'b00;
    step();
    req_valid = 2'b01;
    settle();
    step();
    req_valid = 2'b00;
    settle();
    step();
    reset_n = 1'b0;
    pready  = 1'b1;
    settle();
    n_total++;
    if (penable !== 1'b1) $display("FAIL rst_pre_access: got pen=%b want 1", penable);
    else n_pass++;
    step();
    req_valid = 2'b11;
    settle();
    n_total++;
    if ({req_ready, psel, penable, pwrite, paddr, pwdata, pstrb} !== '0 ||
        {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, timeout_sticky} !== '0)
      $display("FAIL rst_mid_outputs: got rdy=%b psel=%b pen=%b paddr=%h v=%b e=%b t=%b s=%b",
               req_ready, psel, penable, paddr, rsp_valid, rsp_err, rsp_timeout,
               timeout_sticky);
    else n_pass++;
    step();
    reset_n = 1'b1;
    pready  = 1'b0;
    settle();
    n_total++;
    if (req_ready !== 2'b01 || rsp_valid !== 2'b00)
      $display("FAIL rst_next_grant: got rdy=%b v=%b want 01/00", req_ready, rsp_valid);
    else n_pass++;
    step();
    req_valid = 2'b00;
    settle();
    n_total++;
    if (psel !== 1'b1 || paddr !== 23'h000040)
      $display("FAIL rst_next_setup: got psel=%b paddr=%h want 1/000040", psel, paddr);
    else n_pass++;
    step();
    pready = 1'b1;
    step();
    pready = 1'b0;
    settle();
    n_total++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b0)
      $display("FAIL rst_next_rsp: got v=%b e=%b want 01/0", rsp_valid, rsp_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rr_from_reset();
    test_single_read();
    test_write_wait();
    test_slverr();
    test_timeout();
    test_reset_in_access();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 want finish");
    $fatal(1);
  end

endmodule
